risc_spm_loader: RTL and testbench
==================================

# risc_spm_loader

Synthesizable boot and run controller for the RISC_SPM processor, parametrised in word and address width. After `start`, it owns the processor memory write port and holds the processor in reset. It zero-fills the whole memory, then accepts a program/data image over a valid/ready load stream. It then releases the processor and supervises the run until HALT, or until a watchdog timeout when that feature is compiled in. It sits beside `RISC_SPM`, muxed onto the memory write port, and replaces hierarchical bench pokes for memory flush and program load.

## Interface
- `WORD_SIZE`, 8, memory word width
- `ADDR_SIZE`, 8, memory address width; DEPTH = 2**ADDR_SIZE
- `WDOG_CYCLES`, 140, run-cycle budget before timeout (watchdog builds only)
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle request to flush, load and run
- `ld_valid`  in  1  load word offered
- `ld_ready`  out  1  loader accepts a word; transfer when valid&ready
- `ld_addr`  in  ADDR_SIZE  target address
- `ld_data`  in  WORD_SIZE  word to write
- `ld_last`  in  1  final word of the image
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_SIZE  write address
- `mem_wdata`  out  WORD_SIZE  write data
- `cpu_rst`  out  1  active-low reset to the processor
- `cpu_halt`  in  1  processor executed HALT (level)
- `busy`  out  1  state is FLUSH, LOAD or RUN
- `done`  out  1  run ended by HALT
- `timeout`  out  1  run ended by the watchdog
- `load_count`  out  ADDR_SIZE+1  words accepted this boot; saturates at DEPTH

## Operation
- Reset values: state IDLE; `mem_we`, `mem_addr`, `mem_wdata`, `cpu_rst`, `busy`, `done`, `timeout`, `load_count` all 0; `ld_ready` 0.
- IDLE: `start` -> FLUSH. Flush counter is cleared and `load_count` is cleared.
- FLUSH: writes 0 to addresses 0..DEPTH-1, one per cycle, in ascending order. The counter is ADDR_SIZE+1 bits. After address DEPTH-1 is issued, the state moves to LOAD. There is no wrap-around re-flush.
- LOAD: `ld_ready` = 1. Each transfer writes `ld_data` to `ld_addr` and increments `load_count`. A transfer with `ld_last` set moves the state to RUN. Duplicate addresses: the last write wins.
- RUN: `cpu_rst` released. `cpu_halt` high -> HALTED and `done` = 1.
- HALTED: `cpu_rst` stays high so the processor state and memory remain observable.
- TIMEOUT: `cpu_rst` = 0 and `timeout` = 1.
- HALTED and TIMEOUT: `start` -> FLUSH. This clears `done`/`timeout` and drives `cpu_rst` low on the same edge.
- `start` is ignored in FLUSH, LOAD and RUN.
- `ld_valid` is ignored outside LOAD, because `ld_ready` is low there.
- `cpu_halt` is ignored outside RUN.
- Asserting `rst` mid-operation returns all outputs to their reset values immediately. Memory contents are then undefined and a new `start` is required.

## Timing
- `ld_ready` and `busy` are decodes of the state register.
- `mem_*` and `cpu_rst` are registered: each write appears on the bus one cycle after the cycle that issues it.
- `start` in cycle 0 -> FLUSH in cycle 1 -> zero writes visible in cycles 2..DEPTH+1 -> LOAD from cycle DEPTH+1.
- Load write latency: 1 cycle from handshake to `mem_we`. Throughput is one word per cycle.
- `cpu_rst` rises 2 cycles after the `ld_last` handshake, which is 1 cycle after the final write is on the bus.
- `done`/`timeout` assert 1 cycle after the deciding condition.

## Configuration
- `RISC_SPM_LOADER_WDOG_EN` defined: a run counter starts at `cpu_rst` release. After WDOG_CYCLES RUN cycles without `cpu_halt`, the state goes to TIMEOUT. If `cpu_halt` and expiry fall in the same cycle, HALT wins.
- Macro undefined: no counter, `timeout` is tied to 0, and RUN waits indefinitely for `cpu_halt`. `WDOG_CYCLES` is unused.

## Structure
- Package `risc_spm_pkg` holds:
  - the loader state enum (IDLE, FLUSH, LOAD, RUN, HALTED, TIMEOUT);
  - default `WORD_SIZE`/`ADDR_SIZE`;
  - the HALT opcode constant 4'b1111.
- Sub-module `risc_spm_watchdog` (load, enable, expired) is instantiated only under the macro.

## Test plan
- ADDR_SIZE=4, `start` -> exactly 16 writes of 0x00 at addresses 0..15 on consecutive cycles, then `ld_ready`=1 in cycle 17.
- Load 15 words (addr 0..14 = 0x00, 0x52, 130, 0x53, 131, …, 0x73, 140) plus data at 128..140, with `ld_last` on addr 140 -> each word written 1 cycle after its handshake; `load_count`=28; `cpu_rst` rises 2 cycles after the last handshake.
- Random `ld_valid` gaps of 0–3 cycles -> no lost or duplicated writes; the memory image matches the scoreboard.
- `cpu_halt` raised 10 cycles into RUN -> `done`=1 next cycle, `cpu_rst` stays 1, `busy`=0; a following `start` re-flushes with `cpu_rst`=0.
- With the macro defined and WDOG_CYCLES=8, no halt -> `timeout`=1 and `cpu_rst`=0 after 8 run cycles. With halt and expiry in the same cycle -> `done`=1 and `timeout`=0.
- `rst` low during LOAD after 5 words -> all outputs 0 asynchronously, `load_count`=0. `start` during FLUSH -> ignored; flush count unchanged.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// ---------------------------------------------------------------------------
// risc_spm_pkg
// Shared definitions for the RISC_SPM boot/run loader:
//   - loader state encoding (IDLE, FLUSH, LOAD, RUN, HALTED, TIMEOUT)
//   - default memory word/address widths
//   - HALT opcode of the RISC_SPM instruction set
// ---------------------------------------------------------------------------
package risc_spm_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 8;

  // Upper opcode nibble of the RISC_SPM HALT instruction.
  localparam logic [3:0] HALT_OPCODE = 4'b1111;

  typedef enum logic [2:0] {
    LDR_IDLE    = 3'd0,
    LDR_FLUSH   = 3'd1,
    LDR_LOAD    = 3'd2,
    LDR_RUN     = 3'd3,
    LDR_HALTED  = 3'd4,
    LDR_TIMEOUT = 3'd5
  } loader_state_e;

endpackage

// File: rtl/risc_spm_watchdog.sv
// ---------------------------------------------------------------------------
// risc_spm_watchdog
// Run-cycle budget for the loader. A down-counter is armed by `load` and
// counts cycles while `enable` is high; `expired` flags the cycle that uses
// up the last budgeted cycle (the CYCLES-th enabled cycle after load).
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   load     in   arm the budget (CYCLES enabled cycles)
//   enable   in   count this cycle
//   expired  out  budget used up in this enabled cycle
// Parameter CYCLES must be at least 1.
// ---------------------------------------------------------------------------
module risc_spm_watchdog
  import risc_spm_pkg::*;
#(
  parameter int CYCLES = 140
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // Loaded with CYCLES-1 so that a zero count marks the final budgeted cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(CYCLES - 1);
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/risc_spm_loader.sv
// ---------------------------------------------------------------------------
// risc_spm_loader
// Boot and run controller for the RISC_SPM processor. On `start` it takes the
// processor memory write port, holds the CPU in reset, zero-fills the whole
// memory, accepts an image over a valid/ready stream, then releases the CPU
// and waits for HALT (or a watchdog timeout when compiled in).
//
// Build option: define RISC_SPM_LOADER_WDOG_EN to include the run watchdog
// (risc_spm_watchdog). Without it `timeout` is tied low and RUN waits for
// `cpu_halt` indefinitely.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   start       in   single-cycle request to flush, load and run
//   ld_valid    in   load word offered
//   ld_ready    out  loader accepts a word (LOAD state)
//   ld_addr     in   target address of load word
//   ld_data     in   load word
//   ld_last     in   final word of the image
//   mem_we      out  memory write enable (registered)
//   mem_addr    out  memory write address (registered)
//   mem_wdata   out  memory write data (registered)
//   cpu_rst     out  active-low processor reset (registered)
//   cpu_halt    in   processor executed HALT (level)
//   busy        out  FLUSH, LOAD or RUN
//   done        out  run ended by HALT
//   timeout     out  run ended by the watchdog
//   load_count  out  words accepted this boot, saturating at DEPTH
//
// State   | meaning
// IDLE    | after reset, waiting for start
// FLUSH   | writing zero to every address, ascending
// LOAD    | accepting image words
// RUN     | CPU released, waiting for HALT / watchdog
// HALTED  | CPU halted, kept out of reset for inspection
// TIMEOUT | watchdog fired, CPU held in reset
// ---------------------------------------------------------------------------
module risc_spm_loader
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int ADDR_SIZE   = ADDR_SIZE_DEF,
  parameter int WDOG_CYCLES = 140
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_rst,
  input  logic                 cpu_halt,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [ADDR_SIZE:0]   load_count
);

  localparam int DEPTH = 2 ** ADDR_SIZE;

  localparam logic [2:0] S_IDLE    = LDR_IDLE;
  localparam logic [2:0] S_FLUSH   = LDR_FLUSH;
  localparam logic [2:0] S_LOAD    = LDR_LOAD;
  localparam logic [2:0] S_RUN     = LDR_RUN;
  localparam logic [2:0] S_HALTED  = LDR_HALTED;
  localparam logic [2:0] S_TIMEOUT = LDR_TIMEOUT;

  localparam logic [ADDR_SIZE:0] CNT_DEPTH      = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] CNT_LAST_FLUSH = (ADDR_SIZE + 1)'(DEPTH - 1);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [ADDR_SIZE:0] flush_cnt;
  logic               ld_fire;
  logic               start_fire;
  logic               wdog_expired;

  // CPU reset is released only while the loader stays in RUN/HALTED across
  // an edge, which gives the required one-cycle gap after the last write and
  // drops cpu_rst on the same edge that leaves HALTED or enters TIMEOUT.
  function automatic logic cpu_live(input logic [2:0] s);
    return (s == S_RUN) || (s == S_HALTED);
  endfunction

  assign ld_ready   = (state == S_LOAD);
  assign busy       = (state == S_FLUSH) || (state == S_LOAD) || (state == S_RUN);
  assign ld_fire    = ld_valid && ld_ready;
  assign start_fire = (state_nxt == S_FLUSH) && (state != S_FLUSH);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_cnt == CNT_LAST_FLUSH) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (ld_fire && ld_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        // HALT takes priority over a coincident watchdog expiry.
        if (cpu_halt)          state_nxt = S_HALTED;
        else if (wdog_expired) state_nxt = S_TIMEOUT;
      end
      S_HALTED, S_TIMEOUT: begin
        if (start) state_nxt = S_FLUSH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      flush_cnt  <= '0;
      load_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_we  <= 1'b0;
      cpu_rst <= cpu_live(state) && cpu_live(state_nxt);
      done    <= (state_nxt == S_HALTED);

      if (start_fire) begin
        flush_cnt  <= '0;
        load_count <= '0;
      end

      if (state == S_FLUSH) begin
        mem_we    <= 1'b1;
        mem_addr  <= flush_cnt[ADDR_SIZE-1:0];
        mem_wdata <= '0;
        flush_cnt <= flush_cnt + 1'b1;
      end

      if (ld_fire) begin
        mem_we    <= 1'b1;
        mem_addr  <= ld_addr;
        mem_wdata <= ld_data;
        if (load_count != CNT_DEPTH) load_count <= load_count + 1'b1;
      end
    end
  end

`ifdef RISC_SPM_LOADER_WDOG_EN
  // Budget is armed on the edge that enters RUN and counts RUN cycles.
  risc_spm_watchdog #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .load    (ld_fire && ld_last),
    .enable  (state == S_RUN),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timeout <= 1'b0;
    else      timeout <= (state_nxt == S_TIMEOUT);
  end
`else
  logic wdog_unused;

  assign wdog_unused  = (WDOG_CYCLES != 0);
  assign wdog_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_risc_spm_loader.sv
module tb_risc_spm_loader;

  localparam int AS    = 8;
  localparam int WS    = 8;
  localparam int DEPTH = 256;
  localparam int WDOG  = 8;
`ifdef RISC_SPM_LOADER_WDOG_EN
  localparam int HALT_AT = 5;
`else
  localparam int HALT_AT = 10;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic          ld_valid;
  logic          ld_ready;
  logic [AS-1:0] ld_addr;
  logic [WS-1:0] ld_data;
  logic          ld_last;
  logic          mem_we;
  logic [AS-1:0] mem_addr;
  logic [WS-1:0] mem_wdata;
  logic          cpu_rst;
  logic          cpu_halt;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [AS:0]   load_count;

  risc_spm_loader #(
    .WORD_SIZE   (WS),
    .ADDR_SIZE   (AS),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .cpu_halt   (cpu_halt),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: what memory should hold and how many words were taken.
  logic [WS-1:0] model_mem  [DEPTH];
  logic [WS-1:0] shadow_mem [DEPTH];
  int            model_count;

  // Memory as seen from the write bus.
  always @(negedge clk) begin
    if (mem_we === 1'b1) shadow_mem[mem_addr] = mem_wdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (shadow_mem[i] !== model_mem[i]) begin
        miscompares++;
        $display("FAIL mem_image addr=%0d got=%h exp=%h", i, shadow_mem[i], model_mem[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; ld_valid = 0; ld_addr = '0; ld_data = '0;
    ld_last = 0; cpu_halt = 0;
    for (int i = 0; i < DEPTH; i++) shadow_mem[i] = 8'hA5;
    #2 rst = 1'b0;
    #2;
    vectors++;
    if ({mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, timeout, load_count, ld_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_values got we=%b a=%h d=%h crst=%b busy=%b done=%b to=%b cnt=%0d rdy=%b exp all 0",
               mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, timeout, load_count, ld_ready);
    end
    tick; tick;
    rst = 1'b1;
    tick;
    vectors++;
    if ({busy, ld_ready, mem_we, cpu_rst} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_after_reset got busy=%b rdy=%b we=%b crst=%b exp 0000", busy, ld_ready, mem_we, cpu_rst);
    end
  endtask

  // Drives start, then checks every zero write; ends in the first LOAD cycle.
  task automatic test_flush(input bit poke_start);
    start = 1'b1;
    tick;
    start = 1'b0;
    vectors++;
    if ({busy, mem_we, cpu_rst, done, timeout, ld_ready} !== 6'b100000) begin
      miscompares++;
      $display("FAIL flush_entry got busy=%b we=%b crst=%b done=%b to=%b rdy=%b exp 100000",
               busy, mem_we, cpu_rst, done, timeout, ld_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (poke_start && i == 100) start = 1'b1;
      tick;
      start = 1'b0;
      vectors++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'(i), 8'h00}) begin
        miscompares++;
        $display("FAIL flush_write cyc=%0d got we=%b a=%h d=%h exp we=1 a=%h d=00",
                 i + 2, mem_we, mem_addr, mem_wdata, 8'(i));
      end
      vectors++;
      if (ld_ready !== (i == DEPTH - 1)) begin
        miscompares++;
        $display("FAIL flush_ready cyc=%0d got %b exp %b", i + 2, ld_ready, (i == DEPTH - 1));
      end
    end
    vectors++;
    if (load_count !== '0) begin
      miscompares++;
      $display("FAIL flush_count_clear got %0d exp 0", load_count);
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_count = 0;
  endtask

  task automatic send_word(input logic [AS-1:0] a, input logic [WS-1:0] d,
                           input logic last, input int gap);
    int budget;
    bit got;
    ld_valid = 1'b0;
    repeat (gap) tick;
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    got = 0;
    budget = 0;
    while (!got && budget < 20) begin
      got = ld_ready;
      tick;
      budget++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL handshake_timeout addr=%h got no ready exp ready", a);
    end else begin
      model_mem[a] = d;
      if (model_count < DEPTH) model_count++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, a, d}) begin
        miscompares++;
        $display("FAIL load_write got we=%b a=%h d=%h exp we=1 a=%h d=%h", mem_we, mem_addr, mem_wdata, a, d);
      end
      vectors++;
      if (load_count !== 9'(model_count)) begin
        miscompares++;
        $display("FAIL load_count got %0d exp %0d", load_count, model_count);
      end
    end
    if (last) begin
      vectors++;
      if ({cpu_rst, busy} !== 2'b01) begin
        miscompares++;
        $display("FAIL run_entry got crst=%b busy=%b exp crst=0 busy=1", cpu_rst, busy);
      end
    end
  endtask

  // Entered in the first RUN cycle; raises cpu_halt in RUN cycle n.
  task automatic run_halt(input int n);
    for (int c = 1; c < n; c++) begin
      if (c >= 2) begin
        vectors++;
        if ({mem_we, ld_ready, busy, cpu_rst, done, timeout} !== 6'b001100) begin
          miscompares++;
          $display("FAIL run_cycle r=%0d got we=%b rdy=%b busy=%b crst=%b done=%b to=%b exp 001100",
                   c, mem_we, ld_ready, busy, cpu_rst, done, timeout);
        end
      end
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 8'($urandom);
      ld_data  = 8'($urandom);
      start    = (c == 3);
      tick;
    end
    ld_valid = 1'b0;
    start    = 1'b0;
    cpu_halt = 1'b1;
    tick;
    vectors++;
    if ({done, timeout, cpu_rst, busy, mem_we} !== 5'b10100) begin
      miscompares++;
      $display("FAIL halt_response got done=%b to=%b crst=%b busy=%b we=%b exp 10100",
               done, timeout, cpu_rst, busy, mem_we);
    end
    tick;
    vectors++;
    if ({done, cpu_rst} !== 2'b11) begin
      miscompares++;
      $display("FAIL halted_hold got done=%b crst=%b exp 11", done, cpu_rst);
    end
    check_mem;
  endtask

  task automatic test_image_load;
    logic [WS-1:0] prog [15];
    prog = '{8'h00, 8'h52, 8'd130, 8'h53, 8'd131, 8'h61, 8'd132, 8'h62,
             8'd133, 8'h70, 8'd134, 8'h71, 8'd135, 8'h73, 8'd140};
    for (int i = 0; i < 15; i++) send_word(8'(i), prog[i], 1'b0, 0);
    for (int i = 128; i <= 140; i++) send_word(8'(i), 8'($urandom), (i == 140), 0);
    vectors++;
    if (load_count !== 9'd28) begin
      miscompares++;
      $display("FAIL image_count got %0d exp 28", load_count);
    end
    tick;
    vectors++;
    if ({cpu_rst, mem_we} !== 2'b10) begin
      miscompares++;
      $display("FAIL cpu_release got crst=%b we=%b exp crst=1 we=0", cpu_rst, mem_we);
    end
    run_halt(HALT_AT - 1);
  endtask

  task automatic test_random_gaps;
    int n;
    cpu_halt = 1'b0;
    n = 40;
    for (int i = 0; i < n; i++)
      send_word(8'($urandom_range(0, 31)), 8'($urandom), (i == n - 1), int'($urandom_range(0, 3)));
    run_halt(HALT_AT);
  endtask

  task automatic test_saturation;
    cpu_halt = 1'b0;
    for (int i = 0; i < 300; i++)
      send_word(8'($urandom), 8'($urandom), (i == 299), 0);
    run_halt(HALT_AT);
  endtask

`ifdef RISC_SPM_LOADER_WDOG_EN
  task automatic test_watchdog;
    cpu_halt = 1'b0;
    test_flush(1'b0);
    for (int i = 0; i < 3; i++) send_word(8'(i), 8'($urandom), (i == 2), 0);
    repeat (WDOG - 1) tick;
    vectors++;
    if ({timeout, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL wdog_early got to=%b busy=%b exp to=0 busy=1", timeout, busy);
    end
    tick;
    vectors++;
    if ({timeout, done, cpu_rst, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL wdog_expire got to=%b done=%b crst=%b busy=%b exp 1000", timeout, done, cpu_rst, busy);
    end
    test_flush(1'b0);
    for (int i = 0; i < 2; i++) send_word(8'(i + 50), 8'($urandom), (i == 1), 0);
    repeat (WDOG - 1) tick;
    cpu_halt = 1'b1;
    tick;
    vectors++;
    if ({done, timeout, cpu_rst} !== 3'b101) begin
      miscompares++;
      $display("FAIL wdog_halt_tie got done=%b to=%b crst=%b exp 101", done, timeout, cpu_rst);
    end
    check_mem;
    cpu_halt = 1'b0;
  endtask
`else
  task automatic test_no_watchdog;
    cpu_halt = 1'b0;
    test_flush(1'b0);
    for (int i = 0; i < 2; i++) send_word(8'(i + 70), 8'($urandom), (i == 1), 0);
    repeat (200) tick;
    vectors++;
    if ({timeout, busy, cpu_rst, done} !== 4'b0110) begin
      miscompares++;
      $display("FAIL no_wdog_wait got to=%b busy=%b crst=%b done=%b exp 0110", timeout, busy, cpu_rst, done);
    end
    cpu_halt = 1'b1;
    tick;
    vectors++;
    if ({done, timeout} !== 2'b10) begin
      miscompares++;
      $display("FAIL no_wdog_halt got done=%b to=%b exp 10", done, timeout);
    end
    cpu_halt = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_load;
    cpu_halt = 1'b0;
    test_flush(1'b0);
    for (int i = 0; i < 5; i++) send_word(8'($urandom), 8'($urandom), 1'b0, int'($urandom_range(0, 3)));
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, timeout, load_count, ld_ready} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got we=%b a=%h d=%h crst=%b busy=%b done=%b to=%b cnt=%0d rdy=%b exp all 0",
               mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, timeout, load_count, ld_ready);
    end
    tick;
    rst = 1'b1;
    tick;
    ld_valid = 1'b1; ld_addr = 8'h33; ld_data = 8'h44;
    tick; tick;
    vectors++;
    if ({busy, ld_ready, mem_we, load_count} !== '0) begin
      miscompares++;
      $display("FAIL idle_ignores_load got busy=%b rdy=%b we=%b cnt=%0d exp all 0", busy, ld_ready, mem_we, load_count);
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_flush(1'b1);
    test_image_load;
    test_flush(1'b0);
    test_random_gaps;
    test_flush(1'b0);
    test_saturation;
`ifdef RISC_SPM_LOADER_WDOG_EN
    test_watchdog;
`else
    test_no_watchdog;
`endif
    test_reset_mid_load;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
